clkdiv_sync: RTL and testbench

Programmable synchronous clock divider: the reducing counterpart to the team's x4 clock multiplier. It derives a slower, glitch-free, fully registered clock-enable/clock signal from `clk_in`, dividing by a runtime-loadable integer N. Divisor changes use a req/ack handshake and take effect only at a period boundary. It feeds low-rate peripherals and measurement logic that must stay phase-locked to `clk_in`.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_if.sv | 23 ++
 rtl/clkdiv_sync_phase.sv | 42 ++++
 rtl/clkdiv_sync.sv | 116 +++++++++++
 tb/tb_clkdiv_sync.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types, constants and divisor clamp for clkdiv_sync
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } clkdiv_state_t;

    localparam int unsigned CLKDIV_MIN_DIV = 2;

    // Divisors below 2 cannot produce both a high and a low phase.
    function automatic int unsigned clkdiv_clamp(input int unsigned div);
        return (div < CLKDIV_MIN_DIV) ? CLKDIV_MIN_DIV : div;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// rtl/clkdiv_if.sv - run/divisor handshake and divided-clock outputs of clkdiv_sync
interface clkdiv_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_req;
    logic             div_ack;
    logic             clk_out;
    logic             rise;
    logic             fall;
    logic [DIV_W-1:0] active_div;

    modport master (
        output en, div_in, div_req,
        input  div_ack, clk_out, rise, fall, active_div
    );

    modport slave (
        input  en, div_in, div_req,
        output div_ack, clk_out, rise, fall, active_div
    );
endinterface

// File: rtl/clkdiv_sync_phase.sv
// rtl/clkdiv_sync_phase.sv - clkdiv_phase: one registered phase of the divided clock
module clkdiv_phase
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [DIV_W-1:0] cnt,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] offset,
    input  logic             run,
    output logic             phase
);

    logic [DIV_W:0] c_ext;
    logic [DIV_W:0] n_ext;
    logic [DIV_W:0] o_ext;
    logic [DIV_W:0] pos;

    // (cnt - offset) mod div, with one extra bit so cnt + div cannot overflow
    always_comb begin
        c_ext = {1'b0, cnt};
        n_ext = {1'b0, div};
        o_ext = {1'b0, offset};
        pos   = '0;
        if (c_ext >= o_ext) begin
            pos = c_ext - o_ext;
        end else begin
            pos = c_ext + n_ext - o_ext;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            phase <= 1'b0;
        end else begin
            phase <= run && (pos < (n_ext >> 1));
        end
    end

endmodule

// File: rtl/clkdiv_sync.sv
// rtl/clkdiv_sync.sv - programmable synchronous clock divider; CLKDIV_QUAD_EN adds clk_q
module clkdiv_sync
    import clkdiv_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic clk_in,
    input  logic rst,
`ifdef CLKDIV_QUAD_EN
    output logic clk_q,
`endif
    clkdiv_if.slave bus
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    clkdiv_state_t    state;
    clkdiv_state_t    nxt_state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] nxt_cnt;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] nxt_div;
    logic             div_ack_q;
    logic             nxt_ack;
    logic             rise_q;
    logic             fall_q;
    logic             clk_out_q;
    logic             run_nxt;
    logic             last;
    logic             take;

    // Outputs are registered from the next-state values so they line up with cnt.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_div   = active_div;
        nxt_ack   = 1'b0;
        last      = (cnt == (active_div - ONE));
        take      = bus.div_req && !div_ack_q;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (take) begin
                    nxt_div = DIV_W'(clkdiv_clamp(32'(bus.div_in)));
                    nxt_ack = 1'b1;
                end
                if (bus.en) begin
                    nxt_state = RUN;
                end
            end
            default: begin
                if (last) begin
                    nxt_cnt   = '0;
                    nxt_state = bus.en ? RUN : IDLE;
                    if (take) begin
                        nxt_div = DIV_W'(clkdiv_clamp(32'(bus.div_in)));
                        nxt_ack = 1'b1;
                    end
                end else begin
                    nxt_cnt   = cnt + ONE;
                    nxt_state = bus.en ? RUN : DRAIN;
                end
            end
        endcase
    end

    assign run_nxt = (nxt_state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            active_div <= DIV_W'(DIV_RESET);
            div_ack_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            active_div <= nxt_div;
            div_ack_q  <= nxt_ack;
            rise_q     <= run_nxt && (nxt_cnt == '0);
            fall_q     <= run_nxt && (nxt_cnt == (nxt_div >> 1));
        end
    end

    clkdiv_phase #(.DIV_W(DIV_W)) u_out (
        .clk_in (clk_in),
        .rst    (rst),
        .cnt    (nxt_cnt),
        .div    (nxt_div),
        .offset ('0),
        .run    (run_nxt),
        .phase  (clk_out_q)
    );

`ifdef CLKDIV_QUAD_EN
    clkdiv_phase #(.DIV_W(DIV_W)) u_quad (
        .clk_in (clk_in),
        .rst    (rst),
        .cnt    (nxt_cnt),
        .div    (nxt_div),
        .offset (nxt_div >> 2),
        .run    (run_nxt),
        .phase  (clk_q)
    );
`endif

    assign bus.div_ack    = div_ack_q;
    assign bus.clk_out    = clk_out_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.active_div = active_div;

endmodule

// File: tb/tb_clkdiv_sync.sv
// tb/tb_clkdiv_sync.sv - vector table with scoreboard for clkdiv_sync; CLKDIV_QUAD_EN checks clk_q
module tb_clkdiv_sync;

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] d;
        logic       q;
        logic       co;
        logic       ri;
        logic       fa;
        logic       ak;
        logic [7:0] ad;
    } vec_t;

    typedef struct {
        logic [11:0] bits;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    vec_t tbl[$];
    exp_t sb[$];

    clkdiv_if #(.DIV_W(8)) bus ();

`ifdef CLKDIV_QUAD_EN
    logic clk_q;
    clkdiv_sync #(.DIV_W(8), .DIV_RESET(4)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .clk_q  (clk_q),
        .bus    (bus)
    );
`else
    clkdiv_sync #(.DIV_W(8), .DIV_RESET(4)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );
`endif

    always #5 clk_in = ~clk_in;

    function automatic vec_t v(input int r, input int e, input int d, input int q,
                               input int co, input int ri, input int fa, input int ak,
                               input int ad);
        vec_t x;
        x.r  = r[0];
        x.e  = e[0];
        x.d  = 8'(d);
        x.q  = q[0];
        x.co = co[0];
        x.ri = ri[0];
        x.fa = fa[0];
        x.ak = ak[0];
        x.ad = 8'(ad);
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int n;
        int per;
        int hi;
        exp_t ex;

        bus.en      = 1'b0;
        bus.div_in  = '0;
        bus.div_req = 1'b0;

        // reset, default N=4 run, stop at wrap
        tbl.push_back(v(1,0,0,0, 0,0,0,0,4));
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(0,1,0,0, 1,1,0,0,4)); tbl.push_back(v(0,1,0,0, 1,0,0,0,4));
            tbl.push_back(v(0,1,0,0, 0,0,1,0,4)); tbl.push_back(v(0,1,0,0, 0,0,0,0,4));
        end
        tbl.push_back(v(0,0,0,0, 0,0,0,0,4));
        // odd divisor loaded in IDLE
        tbl.push_back(v(0,0,5,1, 0,0,0,1,5)); tbl.push_back(v(0,0,0,0, 0,0,0,0,5));
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(0,1,0,0, 1,1,0,0,5)); tbl.push_back(v(0,1,0,0, 1,0,0,0,5));
            tbl.push_back(v(0,1,0,0, 0,0,1,0,5)); tbl.push_back(v(0,1,0,0, 0,0,0,0,5));
            tbl.push_back(v(0,1,0,0, 0,0,0,0,5));
        end
        tbl.push_back(v(0,0,0,0, 0,0,0,0,5));
        // mid-run change 4 -> 6, request raised at cnt=1
        tbl.push_back(v(1,0,0,0, 0,0,0,0,4));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,4)); tbl.push_back(v(0,1,0,0, 1,0,0,0,4));
        tbl.push_back(v(0,1,6,1, 0,0,1,0,4)); tbl.push_back(v(0,1,6,1, 0,0,0,0,4));
        tbl.push_back(v(0,1,6,1, 1,1,0,1,6)); tbl.push_back(v(0,1,0,0, 1,0,0,0,6));
        tbl.push_back(v(0,1,0,0, 1,0,0,0,6)); tbl.push_back(v(0,1,0,0, 0,0,1,0,6));
        tbl.push_back(v(0,1,0,0, 0,0,0,0,6)); tbl.push_back(v(0,1,0,0, 0,0,0,0,6));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,6)); tbl.push_back(v(0,1,0,0, 1,0,0,0,6));
        tbl.push_back(v(0,1,0,0, 1,0,0,0,6)); tbl.push_back(v(0,1,0,0, 0,0,1,0,6));
        tbl.push_back(v(0,1,0,0, 0,0,0,0,6)); tbl.push_back(v(0,1,0,0, 0,0,0,0,6));
        tbl.push_back(v(0,0,0,0, 0,0,0,0,6));
        // N=8: drain after en drops at cnt=1, then re-enable at cnt=5
        tbl.push_back(v(0,0,8,1, 0,0,0,1,8)); tbl.push_back(v(0,0,0,0, 0,0,0,0,8));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,8)); tbl.push_back(v(0,1,0,0, 1,0,0,0,8));
        tbl.push_back(v(0,0,0,0, 1,0,0,0,8)); tbl.push_back(v(0,0,0,0, 1,0,0,0,8));
        tbl.push_back(v(0,0,0,0, 0,0,1,0,8)); tbl.push_back(v(0,0,0,0, 0,0,0,0,8));
        tbl.push_back(v(0,0,0,0, 0,0,0,0,8)); tbl.push_back(v(0,0,0,0, 0,0,0,0,8));
        tbl.push_back(v(0,0,0,0, 0,0,0,0,8)); tbl.push_back(v(0,0,0,0, 0,0,0,0,8));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,8)); tbl.push_back(v(0,1,0,0, 1,0,0,0,8));
        tbl.push_back(v(0,0,0,0, 1,0,0,0,8)); tbl.push_back(v(0,0,0,0, 1,0,0,0,8));
        tbl.push_back(v(0,0,0,0, 0,0,1,0,8)); tbl.push_back(v(0,0,0,0, 0,0,0,0,8));
        tbl.push_back(v(0,1,0,0, 0,0,0,0,8)); tbl.push_back(v(0,1,0,0, 0,0,0,0,8));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,8));
        tbl.push_back(v(1,1,0,0, 0,0,0,0,4)); tbl.push_back(v(0,0,0,0, 0,0,0,0,4));
        // N=1 and N=0 clamp to 2; reset mid-period
        tbl.push_back(v(0,0,1,1, 0,0,0,1,2)); tbl.push_back(v(0,0,0,0, 0,0,0,0,2));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,2)); tbl.push_back(v(0,1,0,0, 0,0,1,0,2));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,2)); tbl.push_back(v(0,1,0,0, 0,0,1,0,2));
        tbl.push_back(v(0,1,0,0, 1,1,0,0,2));
        tbl.push_back(v(1,1,0,0, 0,0,0,0,4));
        tbl.push_back(v(0,0,0,1, 0,0,0,1,2)); tbl.push_back(v(0,0,0,0, 0,0,0,0,2));
        // wrap with en low and a pending request: adopt, ack, go IDLE
        tbl.push_back(v(0,1,0,0, 1,1,0,0,2)); tbl.push_back(v(0,0,3,1, 0,0,1,0,2));
        tbl.push_back(v(0,0,3,1, 0,0,0,1,3)); tbl.push_back(v(0,0,0,0, 0,0,0,0,3));

        foreach (tbl[i]) begin
            rst         = tbl[i].r;
            bus.en      = tbl[i].e;
            bus.div_in  = tbl[i].d;
            bus.div_req = tbl[i].q;
            ex.bits     = {tbl[i].co, tbl[i].ri, tbl[i].fa, tbl[i].ak, tbl[i].ad};
            sb.push_back(ex);
            tick();
            ex = sb.pop_front();
            chk($sformatf("row%0d {clk_out,rise,fall,ack,div}", i),
                int'({bus.clk_out, bus.rise, bus.fall, bus.div_ack, bus.active_div}),
                int'(ex.bits));
        end
        rst         = 1'b0;
        bus.en      = 1'b0;
        bus.div_req = 1'b0;

        // N=7 loaded in IDLE: measure period and high time between rises
        bus.div_in  = 8'd7;
        bus.div_req = 1'b1;
        tick();
        chk("n7_ack", int'(bus.div_ack), 1);
        chk("n7_div", int'(bus.active_div), 7);
        bus.div_req = 1'b0;
        bus.en      = 1'b1;
        n = 0;
        while (!bus.rise && n < 20) begin
            tick();
            n++;
        end
        chk("n7_rise_seen", int'(bus.rise), 1);
        per = 0;
        hi  = 0;
        do begin
            hi += int'(bus.clk_out);
            tick();
            per++;
        end while (!bus.rise && per < 20);
        chk("n7_period", per, 7);
        chk("n7_high", hi, 3);
        bus.en = 1'b0;
        repeat (10) tick();
        chk("n7_idle_clk_out", int'(bus.clk_out), 0);
        chk("n7_idle_div", int'(bus.active_div), 7);

`ifdef CLKDIV_QUAD_EN
        begin
            logic [7:0] qbits;
            logic [7:0] obits;
            bus.div_in  = 8'd8;
            bus.div_req = 1'b1;
            tick();
            bus.div_req = 1'b0;
            chk("quad_idle_clk_q", int'(clk_q), 0);
            bus.en = 1'b1;
            n = 0;
            while (!bus.rise && n < 20) begin
                tick();
                n++;
            end
            chk("quad_rise_seen", int'(bus.rise), 1);
            qbits[7] = clk_q;
            obits[7] = bus.clk_out;
            for (int b = 6; b >= 0; b--) begin
                tick();
                qbits[b] = clk_q;
                obits[b] = bus.clk_out;
            end
            chk("quad_clk_q", int'(qbits), 8'b0011_1100);
            chk("quad_clk_out", int'(obits), 8'b1111_0000);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("quad_rst_clk_q", int'(clk_q), 0);
            bus.en = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
